// File: rtl/mmfl_pkg.sv
// -----------------------------------------------------------------------------
// mmfl_pkg
// Shared types and constants for the MinMax frame loader.
//   mmfl_state_e : loader phase (FILL, BURST, HOLD, DRAIN)
//   FRAME_LEN    : samples per frame
//   IDX_W        : width of a frame index / finder register index
// -----------------------------------------------------------------------------
package mmfl_pkg;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BURST = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } mmfl_state_e;

endpackage

// File: rtl/mmfl_frame_buf.sv
// -----------------------------------------------------------------------------
// mmfl_frame_buf
// FRAME_LEN x DATA_W register array holding one frame of samples.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears every entry)
//   we         : write enable
//   waddr      : write index
//   wdata      : write data
//   raddr      : read index (combinational read)
//   rdata      : read data
// -----------------------------------------------------------------------------
module mmfl_frame_buf
  import mmfl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [FRAME_LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/minmax_frame_loader.sv
// -----------------------------------------------------------------------------
// minmax_frame_loader
// Gathers 8 samples per frame from a valid/ready stream, writes them into the
// MinMax finder as one unbroken 8-cycle WriteEn burst, keeps WriteEn high
// until the finder reports Valid, then hands Min/Max to the consumer over a
// valid/ready result port. Dropping WriteEn in DRAIN resets the finder.
//
// state | meaning
// FILL  | accept samples into the frame buffer (in_ready=1)
// BURST | write buf[0..7] into the finder, one register per cycle
// HOLD  | rewrite reg 7 to keep the finder enabled, wait for mm_valid
// DRAIN | WriteEn low, present result until out_ready
//
// Optional macro MMFL_TIMEOUT_EN: bounds HOLD to HOLD_TIMEOUT cycles and
// returns an error result (out_err=1, min/max=0) on expiry. Undefined, HOLD
// waits indefinitely and out_err is tied low.
//
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   in_valid, in_ready, in_data    : sample stream
//   WriteEn, WriteReg, WriteData   : finder write port
//   mm_valid, mm_min, mm_max       : finder result
//   out_valid, out_ready           : result handshake
//   out_min, out_max, out_err      : result payload
// -----------------------------------------------------------------------------
module minmax_frame_loader
  import mmfl_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int HOLD_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              WriteEn,
  output logic [IDX_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic              mm_valid,
  input  logic [DATA_W-1:0] mm_min,
  input  logic [DATA_W-1:0] mm_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic              out_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  mmfl_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_min_q, out_min_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;

  logic              buf_we;
  logic [IDX_W-1:0]  buf_raddr;
  logic [DATA_W-1:0] buf_rdata;

`ifdef MMFL_TIMEOUT_EN
  localparam int HC_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_TIMEOUT - 1);

  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            out_err_q, out_err_d;
`else
  // HOLD_TIMEOUT only matters when the timeout is built in.
  logic unused_hold_timeout;
  assign unused_hold_timeout = ^HOLD_TIMEOUT;
`endif

  // Frame storage. In HOLD the read index is pinned to the last register so
  // the rewrite is idempotent while idx_q has already wrapped to 0.
  assign buf_we    = (state_q == FILL) && in_valid;
  assign buf_raddr = (state_q == HOLD) ? LAST_IDX : idx_q;

  mmfl_frame_buf #(
    .DATA_W (DATA_W)
  ) u_frame_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (in_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_min_d   = out_min_q;
    out_max_d   = out_max_q;
`ifdef MMFL_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      FILL: begin
        if (in_valid) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = HOLD;
`ifdef MMFL_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      HOLD: begin
        // mm_valid is checked first so it wins over a coincident timeout.
        if (mm_valid) begin
          out_min_d   = mm_min;
          out_max_d   = mm_max;
          out_valid_d = 1'b1;
          state_d     = DRAIN;
`ifdef MMFL_TIMEOUT_EN
          out_err_d   = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          out_min_d   = '0;
          out_max_d   = '0;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          state_d     = DRAIN;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
`endif
        end
      end
      DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          idx_d       = '0;
          state_d     = FILL;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Finder-facing outputs decode from registered state/idx and buffer only.
  always_comb begin
    in_ready  = 1'b0;
    WriteEn   = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
      end
      BURST: begin
        WriteEn   = 1'b1;
        WriteReg  = idx_q;
        WriteData = buf_rdata;
      end
      HOLD: begin
        WriteEn   = 1'b1;
        WriteReg  = LAST_IDX;
        WriteData = buf_rdata;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_max_q   <= '0;
    end else begin
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_min_q   <= out_min_d;
      out_max_q   <= out_max_d;
    end
  end

`ifdef MMFL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_min   = out_min_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_minmax_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_minmax_frame_loader
// Self-checking bench for minmax_frame_loader. A frame-level reference model
// predicts every output each cycle; a behavioural MinMax finder answers the
// DUT's write port. Directed frames pin the model with literal expectations,
// then a randomized phase exercises gaps, back-pressure and stray mm_valid.
// Honours MMFL_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_minmax_frame_loader;

  localparam int DATA_W       = 16;
  localparam int HOLD_TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              WriteEn;
  logic [2:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              mm_valid = 1'b0;
  logic [DATA_W-1:0] mm_min = '0;
  logic [DATA_W-1:0] mm_max = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
  logic              out_err;

  always #5 clk = ~clk;

  minmax_frame_loader #(
    .DATA_W       (DATA_W),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .WriteEn   (WriteEn),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .mm_valid  (mm_valid),
    .mm_min    (mm_min),
    .mm_max    (mm_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_err   (out_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int          m_cnt;        // samples gathered in the current frame
  logic [15:0] m_buf [8];
  int          m_burst;      // -1 when not bursting, else register being written
  bit          m_hold;
  bit          m_drain;
  int          m_hold_cyc;
  logic [15:0] m_min, m_max;
  bit          m_err;
  int          m_frames;

  function automatic void model_reset();
    m_cnt = 0; m_burst = -1; m_hold = 0; m_drain = 0; m_hold_cyc = 0;
    m_min = 0; m_max = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_buf[i] = 0;
  endfunction

  function automatic bit m_fill();
    return (m_burst < 0) && !m_hold && !m_drain;
  endfunction

  function automatic void model_update(bit iv, logic [15:0] id, bit orr, bit mv);
    if (m_drain) begin
      if (orr) m_drain = 0;
    end else if (m_hold) begin
      if (mv) begin
        m_hold = 0; m_drain = 1; m_err = 0; m_frames++;
        m_min = m_buf[0]; m_max = m_buf[0];
        for (int i = 1; i < 8; i++) begin
          if (m_buf[i] < m_min) m_min = m_buf[i];
          if (m_buf[i] > m_max) m_max = m_buf[i];
        end
      end else begin
        m_hold_cyc++;
`ifdef MMFL_TIMEOUT_EN
        if (m_hold_cyc == HOLD_TIMEOUT) begin
          m_hold = 0; m_drain = 1; m_err = 1; m_min = 0; m_max = 0; m_frames++;
        end
`endif
      end
    end else if (m_burst >= 0) begin
      m_burst++;
      if (m_burst == 8) begin
        m_burst = -1; m_hold = 1; m_hold_cyc = 0;
      end
    end else if (iv) begin
      m_buf[m_cnt] = id;
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0; m_burst = 0;
      end
    end
  endfunction

  // ---------------- behavioural MinMax finder ----------------
  int          f_cnt;        // consecutive cycles WriteEn has been high
  logic [15:0] f_regs [8];
  int          f_lat;
  int          lat_force = -1;
  bit          stuck = 0;
  bit          noise_en = 0;

  function automatic void finder_reset();
    f_cnt = 0; f_lat = 4;
    for (int i = 0; i < 8; i++) f_regs[i] = 0;
  endfunction

  // Drives mm_* for the coming edge, then absorbs the write the DUT presents.
  task automatic finder_step();
    logic [15:0] mn, mx;
    mn = f_regs[0]; mx = f_regs[0];
    for (int i = 1; i < 8; i++) begin
      if (f_regs[i] < mn) mn = f_regs[i];
      if (f_regs[i] > mx) mx = f_regs[i];
    end
    if (!stuck && f_cnt >= 8 + f_lat) begin
      mm_valid = 1'b1; mm_min = mn; mm_max = mx;
    end else begin
      mm_valid = noise_en && (f_cnt == 0) && ($urandom_range(0, 3) == 0);
      mm_min   = 16'($urandom);
      mm_max   = 16'($urandom);
    end
    if (WriteEn === 1'b1) begin
      f_regs[WriteReg] = WriteData;
      f_cnt++;
    end else begin
      f_cnt = 0;
      f_lat = (lat_force >= 0) ? lat_force : int'($urandom_range(1, 10));
    end
  endtask

  // ---------------- per-cycle compare and stimulus ----------------
  typedef struct {
    bit we;
    int rg;
    int dt;
    bit rdy;
  } log_t;
  log_t wlog [$];

  task automatic check_outputs();
    int er;
    bit ew;
    ew = (m_burst >= 0) || m_hold;
    er = m_hold ? 7 : ((m_burst >= 0) ? m_burst : 0);
    chk("in_ready", in_ready, m_fill());
    chk("WriteEn", WriteEn, ew);
    if (ew || m_fill()) begin
      chk("WriteReg", WriteReg, er);
      chk("WriteData", WriteData, ew ? m_buf[er] : 16'd0);
    end
    chk("out_valid", out_valid, m_drain);
    chk("out_min", out_min, m_min);
    chk("out_max", out_max, m_max);
    chk("out_err", out_err, m_err);
  endtask

  task automatic cycle(input bit iv, input logic [15:0] id, input bit orr);
    log_t e;
    @(negedge clk);
    check_outputs();
    e.we = WriteEn; e.rg = int'(WriteReg); e.dt = int'(WriteData); e.rdy = in_ready;
    wlog.push_back(e);
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    finder_step();
    @(posedge clk);
    model_update(iv, id, orr, mm_valid);
  endtask

  task automatic wait_result(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      cycle(1'b0, 16'($urandom), 1'b0);
      #1;
      if (out_valid === 1'b1) break;
    end
    chk(name, out_valid, 1'b1);
  endtask

  task automatic feed(input logic [15:0] f [8]);
    for (int k = 0; k < 8; k++) cycle(1'b1, f[k], 1'b0);
  endtask

  function automatic int first_we();
    for (int i = 0; i < wlog.size(); i++) if (wlog[i].we) return i;
    return -1;
  endfunction

  function automatic int we_count();
    int n = 0;
    foreach (wlog[i]) if (wlog[i].we) n++;
    return n;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fr1 [8];
    logic [15:0] fr2 [8];
    int fw, gaps, found;

    fr1 = '{16'd5, 16'd9, 16'd1, 16'd7, 16'd3, 16'd8, 16'd2, 16'd6};
    fr2 = '{16'd40, 16'd12, 16'd33, 16'd70, 16'd5, 16'd61, 16'd28, 16'd9};
    model_reset();
    finder_reset();
    m_frames = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_WriteEn", WriteEn, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_minmax", {out_min, out_max}, 32'd0);
    chk("rst_out_err", out_err, 1'b0);
    rst_n = 1'b1;

    // Back-to-back frame 5,9,1,7,3,8,2,6.
    wlog.delete();
    feed(fr1);
    wait_result("f1_result_wait", 60);
    chk("f1_out_min", out_min, 16'd1);
    chk("f1_out_max", out_max, 16'd9);
    chk("f1_out_err", out_err, 1'b0);
    chk("f1_we_low_in_drain", WriteEn, 1'b0);
    fw = first_we();
    chk("f1_burst_start", fw, 8);
    chk("f1_rdy_last_accept", wlog[7].rdy, 1'b1);
    chk("f1_rdy_after_accept", wlog[8].rdy, 1'b0);
    if (fw >= 0 && fw + 8 <= wlog.size()) begin
      for (int k = 0; k < 8; k++) begin
        chk("f1_burst_reg", wlog[fw + k].rg, k);
        chk("f1_burst_data", wlog[fw + k].dt, fr1[k]);
      end
      gaps = 0;
      for (int i = fw; i < wlog.size(); i++) if (!wlog[i].we) gaps++;
      chk("f1_we_gaps", gaps, 0);
    end

    // Back-pressure in DRAIN with in_valid offered.
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), 1'b0);
    #1;
    chk("stall_out_valid", out_valid, 1'b1);
    chk("stall_out_min", out_min, 16'd1);
    chk("stall_out_max", out_max, 16'd9);
    chk("stall_in_ready", in_ready, 1'b0);
    cycle(1'b0, 16'd0, 1'b1);

    // in_valid toggling every cycle during FILL.
    wlog.delete();
    for (int i = 0; i < 16; i++) cycle((i % 2) == 0, 16'(100 + i), 1'b0);
    wait_result("tog_result_wait", 60);
    fw = first_we();
    chk("tog_burst_start", fw, 15);
    if (fw >= 0 && fw + 8 <= wlog.size()) begin
      for (int k = 0; k < 8; k++) chk("tog_burst_data", wlog[fw + k].dt, 100 + 2 * k);
      gaps = 0;
      for (int i = fw; i < wlog.size(); i++) if (!wlog[i].we) gaps++;
      chk("tog_we_gaps", gaps, 0);
    end
    chk("tog_out_min", out_min, 16'd100);
    chk("tog_out_max", out_max, 16'd114);
    cycle(1'b0, 16'd0, 1'b1);

    // Reset pulse in BURST at idx 4.
    feed(fr1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'd0, 1'b0);
      #1;
      if (WriteEn === 1'b1 && WriteReg == 3'd4) begin
        found = 1;
        break;
      end
    end
    chk("rst_burst_idx4_found", found, 1);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_async_WriteEn", WriteEn, 1'b0);
    chk("rst_async_in_ready", in_ready, 1'b1);
    model_reset();
    finder_reset();
    @(negedge clk);
    rst_n = 1'b1;
    feed(fr2);
    wait_result("f2_result_wait", 60);
    chk("f2_out_min", out_min, 16'd5);
    chk("f2_out_max", out_max, 16'd70);
    cycle(1'b0, 16'd0, 1'b1);

    // Finder that never answers.
    stuck = 1;
    wlog.delete();
    feed(fr1);
`ifdef MMFL_TIMEOUT_EN
    wait_result("to_result_wait", 80);
    chk("to_out_err", out_err, 1'b1);
    chk("to_out_minmax", {out_min, out_max}, 32'd0);
    chk("to_we_cycles", we_count(), 8 + HOLD_TIMEOUT);
    cycle(1'b0, 16'd0, 1'b1);
    stuck = 0;
    lat_force = HOLD_TIMEOUT - 1;
    wlog.delete();
    feed(fr1);
    wait_result("late_result_wait", 80);
    chk("late_out_err", out_err, 1'b0);
    chk("late_out_min", out_min, 16'd1);
    chk("late_out_max", out_max, 16'd9);
    chk("late_we_cycles", we_count(), 8 + HOLD_TIMEOUT);
    lat_force = -1;
    cycle(1'b0, 16'd0, 1'b1);
`else
    for (int i = 0; i < 60; i++) cycle(1'b0, 16'($urandom), 1'b0);
    #1;
    chk("stuck_out_valid", out_valid, 1'b0);
    chk("stuck_WriteEn", WriteEn, 1'b1);
    stuck = 0;
    wait_result("stuck_result_wait", 40);
    chk("stuck_out_min", out_min, 16'd1);
    chk("stuck_out_max", out_max, 16'd9);
    chk("stuck_out_err", out_err, 1'b0);
    cycle(1'b0, 16'd0, 1'b1);
`endif

    // Randomized traffic against the model.
    noise_en = 1;
    m_frames = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) == 0);
    end
    chk("rand_frames_seen", m_frames >= 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
